// File: rtl/rd_serial_capture_if.sv
// Port bundle for rd_serial_capture: RD serial lanes, trigger-module handshake,
// AXI control/status and the buffer-RAM write side.
interface rd_serial_capture_if #(
  parameter int N_CHAN = 2
);
  logic [N_CHAN-1:0] SERIAL_DATA_IN;
  logic              ENABLE_XFR_IN;
  logic              TRIG_IN;
  logic [1:0]        BUF_WNUM;
  logic [1:0]        BUF_RNUM;
  logic [31:0]       AXI_CONTROL;
  logic              AXI_CONTROL_WRITTEN;
  logic [31:0]       STATUS;
  logic [31:0]       DATA_ADDR;
  logic [31:0]       DATA_TO_MEM;
  logic              ENABLE_MEM_WRT;
  logic              TRIG_OUT;

  modport master (
    output SERIAL_DATA_IN, ENABLE_XFR_IN, TRIG_IN, BUF_WNUM, BUF_RNUM,
           AXI_CONTROL, AXI_CONTROL_WRITTEN,
    input  STATUS, DATA_ADDR, DATA_TO_MEM, ENABLE_MEM_WRT, TRIG_OUT
  );

  modport slave (
    input  SERIAL_DATA_IN, ENABLE_XFR_IN, TRIG_IN, BUF_WNUM, BUF_RNUM,
           AXI_CONTROL, AXI_CONTROL_WRITTEN,
    output STATUS, DATA_ADDR, DATA_TO_MEM, ENABLE_MEM_WRT, TRIG_OUT
  );
endinterface

// File: rtl/rd_serial_capture.sv
// N_CHAN-lane RD serial receiver: trigger -> armed -> transfer FSM, per-lane word capture and
// lane-by-lane drain into buffer RAM. Define RD_TIMEOUT_EN to abort an ARMED state after TIMEOUT cycles.
module rd_serial_capture #(
  parameter int N_CHAN       = 2,
  parameter int WORD_BITS    = 12,
  parameter int N_BUF        = 4,
  parameter int BUF_WORDS    = 2048,
  parameter int TRIG_OUT_LEN = 4,
  parameter int TIMEOUT      = 4096
) (
  input  logic               SERIAL_CLK_IN,
  input  logic               RST,
  rd_serial_capture_if.slave bus
);
  localparam int WPB    = BUF_WORDS / N_CHAN;
  localparam int IDX_W  = $clog2(BUF_WORDS);
  localparam int BIT_W  = $clog2(WORD_BITS + 1);
  localparam int WIDX_W = $clog2(WPB + 1);
  localparam int LANE_W = (N_CHAN > 1) ? $clog2(N_CHAN) : 1;
  localparam int TOL_W  = $clog2(TRIG_OUT_LEN + 1);
  localparam logic [3:0] BUF_MASK = 4'((1 << N_BUF) - 1);

  typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, XFER = 3'd2} state_t;

  // Reset asserts immediately, releases two clocks later.
  logic [1:0] rst_sync;
  logic       rst_i;
  always_ff @(posedge SERIAL_CLK_IN or posedge RST) begin
    if (RST) rst_sync <= 2'b11;
    else     rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_i = rst_sync[1];

  logic [2:0] trig_sync, wr_sync;
  logic       en_q;
  logic       trig_rise, rel_rise, en_rise;
  always_ff @(posedge SERIAL_CLK_IN or posedge rst_i) begin
    if (rst_i) begin
      trig_sync <= '0;
      wr_sync   <= '0;
      en_q      <= 1'b0;
    end else begin
      trig_sync <= {trig_sync[1:0], bus.TRIG_IN};
      wr_sync   <= {wr_sync[1:0], bus.AXI_CONTROL_WRITTEN};
      en_q      <= bus.ENABLE_XFR_IN;
    end
  end
  assign trig_rise = trig_sync[1] & ~trig_sync[2];
  assign rel_rise  = wr_sync[1] & ~wr_sync[2];
  assign en_rise   = bus.ENABLE_XFR_IN & ~en_q;

  state_t state_q, state_d;
  logic   arm, xfer_start, xfer_end;
`ifdef RD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_expired, tmo_hit;
  assign tmo_expired = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  always_ff @(posedge SERIAL_CLK_IN or posedge rst_i) begin
    if (rst_i)                 tmo_cnt <= '0;
    else if (state_q != ARMED) tmo_cnt <= '0;
    else                       tmo_cnt <= tmo_cnt + 1'b1;
  end
`endif

  always_ff @(posedge SERIAL_CLK_IN or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    arm        = 1'b0;
    xfer_start = 1'b0;
    xfer_end   = 1'b0;
`ifdef RD_TIMEOUT_EN
    tmo_hit    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (trig_rise) begin
          state_d = ARMED;
          arm     = 1'b1;
        end
      end
      ARMED: begin
        if (en_rise) begin
          state_d    = XFER;
          xfer_start = 1'b1;
        end
`ifdef RD_TIMEOUT_EN
        else if (tmo_expired) begin
          state_d = IDLE;
          tmo_hit = 1'b1;
        end
`endif
      end
      XFER: begin
        if (!bus.ENABLE_XFR_IN) begin
          state_d  = IDLE;
          xfer_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [BIT_W-1:0]  bit_cnt;
  logic [WIDX_W-1:0] word_idx;
  logic              shift_en, capture, room;
  assign shift_en = (state_q == XFER) && bus.ENABLE_XFR_IN;
  assign capture  = shift_en && (bit_cnt == BIT_W'(WORD_BITS));
  assign room     = (word_idx < WIDX_W'(WPB));

  always_ff @(posedge SERIAL_CLK_IN or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt  <= '0;
      word_idx <= '0;
    end else if (xfer_start) begin
      bit_cnt  <= '0;
      word_idx <= '0;
    end else if (capture) begin
      bit_cnt <= '0;
      if (room) word_idx <= word_idx + 1'b1;
    end else if (shift_en) begin
      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Stage p0: per-lane shift and running parity.
  logic [WORD_BITS-1:0] sh_p0 [N_CHAN];
  logic [N_CHAN-1:0]    par_p0;
  logic [N_CHAN-1:0]    perr_lane;
  logic [WORD_BITS:0]   hold_p1 [N_CHAN];
  logic [IDX_W-1:0]     base_p1;
  logic [1:0]           buf_p1;
  logic [1:0]           lbuf_q;

  always_comb begin
    perr_lane = '0;
    for (int l = 0; l < N_CHAN; l++)
      perr_lane[l] = ~(par_p0[l] ^ bus.SERIAL_DATA_IN[l]);
  end

  always_ff @(posedge SERIAL_CLK_IN) begin
    for (int l = 0; l < N_CHAN; l++) begin
      if (shift_en) sh_p0[l] <= {sh_p0[l][WORD_BITS-2:0], bus.SERIAL_DATA_IN[l]};
      if (xfer_start || capture) par_p0[l] <= 1'b0;
      else if (shift_en)         par_p0[l] <= par_p0[l] ^ bus.SERIAL_DATA_IN[l];
      if (capture) hold_p1[l] <= {sh_p0[l], bus.SERIAL_DATA_IN[l]};
    end
    if (capture) begin
      base_p1 <= IDX_W'(word_idx * N_CHAN);
      buf_p1  <= lbuf_q;
    end
  end

  // Stage p1: drain holding registers one lane per cycle.
  logic              vld_p1;
  logic [LANE_W-1:0] lane_p1;
  always_ff @(posedge SERIAL_CLK_IN or posedge rst_i) begin
    if (rst_i) begin
      vld_p1  <= 1'b0;
      lane_p1 <= '0;
    end else if (capture && room) begin
      vld_p1  <= 1'b1;
      lane_p1 <= '0;
    end else if (vld_p1) begin
      if (lane_p1 == LANE_W'(N_CHAN - 1)) vld_p1 <= 1'b0;
      else                                lane_p1 <= lane_p1 + 1'b1;
    end
  end

  // Stage p2: registered memory write port.
  logic        vld_p2;
  logic [31:0] addr_p2, data_p2;
  always_ff @(posedge SERIAL_CLK_IN or posedge rst_i) begin
    if (rst_i) begin
      vld_p2  <= 1'b0;
      addr_p2 <= '0;
      data_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        addr_p2 <= (32'(buf_p1) << (IDX_W + 2)) | (32'(base_p1 + IDX_W'(lane_p1)) << 2);
        data_p2 <= (32'(lane_p1) << 24) | 32'(hold_p1[lane_p1]);
      end
    end
  end

  logic [3:0]       full_q, busy_q, perr_q, ovfl_q, tmo_q;
  logic [1:0]       rnum_q;
  logic [3:0]       lbuf_oh, wbuf_oh, rel_oh;
  logic [TOL_W-1:0] trig_cnt;
  assign lbuf_oh = 4'b0001 << lbuf_q;
  assign wbuf_oh = 4'b0001 << bus.BUF_WNUM;
  assign rel_oh  = rel_rise ? (4'b0001 << bus.AXI_CONTROL[1:0]) : 4'b0000;

  // A release and a completion on the same buffer in one cycle leave it full.
  always_ff @(posedge SERIAL_CLK_IN or posedge rst_i) begin
    if (rst_i) begin
      full_q   <= '0;
      busy_q   <= '0;
      perr_q   <= '0;
      ovfl_q   <= '0;
      lbuf_q   <= '0;
      rnum_q   <= '0;
      trig_cnt <= '0;
    end else begin
      rnum_q <= bus.BUF_RNUM;
      full_q <= ((full_q & ~rel_oh) | (xfer_end ? lbuf_oh : 4'b0000)) & BUF_MASK;
      if (xfer_start)    busy_q <= (busy_q | lbuf_oh) & BUF_MASK;
      else if (xfer_end) busy_q <= busy_q & ~lbuf_oh;
      if (arm) begin
        lbuf_q <= bus.BUF_WNUM;
        perr_q <= perr_q & ~wbuf_oh;
        ovfl_q <= ovfl_q & ~wbuf_oh;
      end else begin
        if (capture && (|perr_lane)) perr_q <= (perr_q | lbuf_oh) & BUF_MASK;
        if (capture && !room)        ovfl_q <= (ovfl_q | lbuf_oh) & BUF_MASK;
      end
      if (arm)                trig_cnt <= TOL_W'(TRIG_OUT_LEN);
      else if (trig_cnt != 0) trig_cnt <= trig_cnt - 1'b1;
    end
  end

`ifdef RD_TIMEOUT_EN
  always_ff @(posedge SERIAL_CLK_IN or posedge rst_i) begin
    if (rst_i)        tmo_q <= '0;
    else if (arm)     tmo_q <= tmo_q & ~wbuf_oh;
    else if (tmo_hit) tmo_q <= (tmo_q | lbuf_oh) & BUF_MASK;
  end
`else
  assign tmo_q = 4'b0000;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.AXI_CONTROL[31:2], 1'(TIMEOUT)};

  assign bus.STATUS = {5'b0, state_q, rnum_q, lbuf_q, tmo_q, ovfl_q, perr_q, busy_q, full_q};
  assign bus.DATA_ADDR      = addr_p2;
  assign bus.DATA_TO_MEM    = data_p2;
  assign bus.ENABLE_MEM_WRT = vld_p2;
  assign bus.TRIG_OUT       = (trig_cnt != 0);
endmodule

// File: tb/tb_rd_serial_capture.sv
// Randomized bench for rd_serial_capture: words are generated per lane, the expected write
// stream and status flags are derived from the word list and compared against what the DUT emits.
`timescale 1ns/1ps
module tb_rd_serial_capture;
  localparam int N_CHAN       = 2;
  localparam int WORD_BITS    = 12;
  localparam int N_BUF        = 4;
  localparam int BUF_WORDS    = 8;
  localparam int TRIG_OUT_LEN = 4;
  localparam int TIMEOUT      = 16;
  localparam int WPB          = BUF_WORDS / N_CHAN;

  logic clk = 1'b0;
  logic rst;
  rd_serial_capture_if #(.N_CHAN(N_CHAN)) bus ();

  rd_serial_capture #(
    .N_CHAN(N_CHAN), .WORD_BITS(WORD_BITS), .N_BUF(N_BUF),
    .BUF_WORDS(BUF_WORDS), .TRIG_OUT_LEN(TRIG_OUT_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .SERIAL_CLK_IN(clk),
    .RST(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit         m_full[4], m_perr[4], m_ovfl[4], m_tmo[4];
  logic [1:0] m_lbuf, m_rnum;
  logic [WORD_BITS:0] wq[$];

  logic [31:0] obs_addr[$], obs_data[$];
  int          trig_in_xfer = 0;

  always @(negedge clk) begin
    if (bus.ENABLE_MEM_WRT === 1'b1) begin
      obs_addr.push_back(bus.DATA_ADDR);
      obs_data.push_back(bus.DATA_TO_MEM);
    end
    if (bus.STATUS[26:24] == 3'd2 && bus.TRIG_OUT === 1'b1) trig_in_xfer++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input int st);
    logic [31:0] s;
    s = '0;
    for (int b = 0; b < 4; b++) begin
      s[b]      = m_full[b];
      s[4 + b]  = (st == 2) && (m_lbuf == 2'(b));
      s[8 + b]  = m_perr[b];
      s[12 + b] = m_ovfl[b];
      s[16 + b] = m_tmo[b];
    end
    s[21:20] = m_lbuf;
    s[23:22] = m_rnum;
    s[26:24] = 3'(st);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random_bits();
    for (int l = 0; l < N_CHAN; l++) bus.SERIAL_DATA_IN[l] = 1'($urandom);
  endtask

  task automatic fill_words(input int n, input int bad);
    logic [WORD_BITS-1:0] d;
    logic                 p;
    wq.delete();
    for (int w = 0; w < n; w++)
      for (int l = 0; l < N_CHAN; l++) begin
        d = WORD_BITS'($urandom);
        p = ~(^d);
        if (w == bad && l == N_CHAN - 1) p = ~p;
        wq.push_back({d, p});
      end
  endtask

  task automatic do_trigger(input logic [1:0] b);
    int hi;
    bus.BUF_WNUM = b;
    bus.TRIG_IN  = 1'b1;
    repeat (3) tick();
    bus.TRIG_IN = 1'b0;
    m_lbuf = b;
    m_perr[b] = 1'b0;
    m_ovfl[b] = 1'b0;
    m_tmo[b]  = 1'b0;
    check_eq("arm_status", bus.STATUS, exp_status(1));
    hi = 0;
    repeat (8) begin
      if (bus.TRIG_OUT === 1'b1) hi++;
      tick();
    end
    check_eq("trig_out_len", hi, TRIG_OUT_LEN);
  endtask

  // Sends the words in wq (MSB first, parity last) followed by nextra bits of a partial word.
  task automatic xfer(input int nextra, input bit mid_trig);
    int nwords, total, base, tx0, nexp, j;
    bit anybad;
    nwords = wq.size() / N_CHAN;
    total  = nwords * (WORD_BITS + 1) + nextra;
    base   = obs_addr.size();
    tx0    = trig_in_xfer;
    bus.ENABLE_XFR_IN = 1'b1;
    tick();
    check_eq("busy_status", bus.STATUS, exp_status(2));
    for (int i = 0; i < total; i++) begin
      if (i / (WORD_BITS + 1) < nwords) begin
        j = i % (WORD_BITS + 1);
        for (int l = 0; l < N_CHAN; l++)
          bus.SERIAL_DATA_IN[l] = wq[(i / (WORD_BITS + 1)) * N_CHAN + l][WORD_BITS - j];
      end else begin
        drive_random_bits();
      end
      if (mid_trig && i == 4) begin
        bus.TRIG_IN  = 1'b1;
        bus.BUF_WNUM = m_lbuf + 2'd1;
      end
      if (mid_trig && i == 7) bus.TRIG_IN = 1'b0;
      tick();
    end
    bus.ENABLE_XFR_IN = 1'b0;
    repeat (N_CHAN + 4) tick();

    nexp   = ((nwords < WPB) ? nwords : WPB) * N_CHAN;
    anybad = 1'b0;
    foreach (wq[k]) if (^wq[k] == 1'b0) anybad = 1'b1;
    m_full[m_lbuf] = 1'b1;
    if (anybad) m_perr[m_lbuf] = 1'b1;
    if (nwords > WPB) m_ovfl[m_lbuf] = 1'b1;

    check_eq("write_count", obs_addr.size() - base, nexp);
    for (int k = 0; k < nexp && base + k < obs_addr.size(); k++) begin
      check_eq("wr_addr", obs_addr[base + k], (32'(m_lbuf) * BUF_WORDS + k) * 4);
      check_eq("wr_data", obs_data[base + k], (32'(k % N_CHAN) << 24) | 32'(wq[k]));
    end
    check_eq("trig_out_in_xfer", trig_in_xfer - tx0, 0);
    check_eq("end_status", bus.STATUS, exp_status(0));
  endtask

  task automatic release_buf(input logic [1:0] b);
    bus.AXI_CONTROL = {30'($urandom), b};
    bus.AXI_CONTROL_WRITTEN = 1'b1;
    repeat (3) tick();
    bus.AXI_CONTROL_WRITTEN = 1'b0;
    repeat (2) tick();
    m_full[b] = 1'b0;
    check_eq("release_status", bus.STATUS, exp_status(0));
  endtask

  task automatic clear_model();
    for (int b = 0; b < 4; b++) begin
      m_full[b] = 1'b0; m_perr[b] = 1'b0; m_ovfl[b] = 1'b0; m_tmo[b] = 1'b0;
    end
    m_lbuf = 2'd0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_status"}, bus.STATUS, 32'h0);
    check_eq({tag, "_addr"}, bus.DATA_ADDR, 32'h0);
    check_eq({tag, "_data"}, bus.DATA_TO_MEM, 32'h0);
    check_eq({tag, "_wr"}, 32'(bus.ENABLE_MEM_WRT), 32'h0);
    check_eq({tag, "_trig"}, 32'(bus.TRIG_OUT), 32'h0);
  endtask

  initial begin
    int k, base, nw, bad;
    logic [WORD_BITS-1:0] d;

    clear_model();
    m_rnum = 2'($urandom);
    rst = 1'b1;
    bus.SERIAL_DATA_IN = '0;
    bus.ENABLE_XFR_IN = 1'b0;
    bus.TRIG_IN = 1'b0;
    bus.BUF_WNUM = 2'd0;
    bus.BUF_RNUM = m_rnum;
    bus.AXI_CONTROL = 32'h0;
    bus.AXI_CONTROL_WRITTEN = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (4) tick();
    check_eq("idle_status", bus.STATUS, exp_status(0));

    // ENABLE without a trigger is ignored.
    base = obs_addr.size();
    bus.ENABLE_XFR_IN = 1'b1;
    repeat (20) begin drive_random_bits(); tick(); end
    bus.ENABLE_XFR_IN = 1'b0;
    tick();
    check_eq("no_trig_writes", obs_addr.size() - base, 0);
    check_eq("no_trig_status", bus.STATUS, exp_status(0));

    // Single word per lane, partial second word discarded.
    wq.delete();
    d = 12'hABC; wq.push_back({d, ~(^d)});
    d = 12'h123; wq.push_back({d, ~(^d)});
    do_trigger(2'd0);
    xfer(WORD_BITS, 1'b0);

    // Bad parity on lane 1 of word 3.
    fill_words(4, 3);
    do_trigger(2'd1);
    xfer(0, 1'b0);

    // Five words into a four-word buffer.
    fill_words(5, -1);
    do_trigger(2'd2);
    xfer(3, 1'b0);

    // Trigger during transfer is ignored, then release.
    fill_words(2, -1);
    do_trigger(2'd3);
    xfer(5, 1'b1);
    release_buf(2'd3);

`ifdef RD_TIMEOUT_EN
    do_trigger(2'd1);
    k = 8;
    while (bus.STATUS[26:24] == 3'd1 && k < 40) begin tick(); k++; end
    check_eq("tmo_cycles", k, TIMEOUT);
    m_tmo[1] = 1'b1;
    check_eq("tmo_status", bus.STATUS, exp_status(0));
`else
    do_trigger(2'd1);
    repeat (32) tick();
    check_eq("armed_wait", bus.STATUS, exp_status(1));
    fill_words(1, -1);
    xfer(0, 1'b0);
`endif

    // Reset in the middle of the second word.
    do_trigger(2'd3);
    bus.ENABLE_XFR_IN = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin drive_random_bits(); tick(); end
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_rst");
    clear_model();
    repeat (2) tick();
    rst = 1'b0;
    base = obs_addr.size();
    repeat (12) begin drive_random_bits(); tick(); end
    check_eq("post_rst_writes", obs_addr.size() - base, 0);
    check_eq("post_rst_status", bus.STATUS, exp_status(0));
    bus.ENABLE_XFR_IN = 1'b0;
    tick();

    for (int it = 0; it < 10; it++) begin
      nw  = $urandom_range(1, 6);
      bad = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nw - 1) : -1;
      fill_words(nw, bad);
      do_trigger(2'($urandom));
      xfer($urandom_range(0, WORD_BITS), 1'($urandom));
      if ($urandom_range(0, 1) == 1) release_buf(2'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "time limit");
  end
endmodule
